// File: rtl/preproc_stream_ctrl.sv
// Source select, saturating DC-offset removal and fixed-length AXI-Stream framing for the preprocessing path.
// Optional: define PREPROC_DROP_CNT_EN to add a saturating 32-bit drop_count output.
module preproc_stream_ctrl #(
  parameter int ADC_WIDTH = 14,
  parameter int NUM_SRC   = 4,
  parameter int SRC_SEL_W = 2,
  parameter int OUT_WIDTH = 16,
  parameter int PKT_LEN_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_enable,
  input  logic [SRC_SEL_W-1:0]         cfg_sel_source,
  input  logic [ADC_WIDTH-1:0]         cfg_offset,
  input  logic [PKT_LEN_W-1:0]         cfg_pkt_len,
  input  logic [PKT_LEN_W-1:0]         cfg_num_pkts,
  input  logic                         start,
  input  logic [NUM_SRC*ADC_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [OUT_WIDTH-1:0]         m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast,
  output logic                         busy,
  output logic                         done,
  output logic                         drop_pulse
`ifdef PREPROC_DROP_CNT_EN
  ,
  output logic [31:0]                  drop_count
`endif
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                 state_reg;
  logic [SRC_SEL_W-1:0]   sel_reg;
  logic [ADC_WIDTH-1:0]   offset_reg;
  logic [PKT_LEN_W-1:0]   pkt_len_reg;
  logic [PKT_LEN_W-1:0]   num_pkts_reg;
  logic [PKT_LEN_W-1:0]   beat_cnt_reg;
  logic [PKT_LEN_W-1:0]   pkt_cnt_reg;
  logic [OUT_WIDTH-1:0]   tdata_reg;
  logic                   tvalid_reg;
  logic                   tlast_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   drop_reg;

  logic [ADC_WIDTH-1:0]        src_arr [NUM_SRC];
  logic [ADC_WIDTH-1:0]        sample;
  logic signed [ADC_WIDTH:0]   diff;
  logic signed [ADC_WIDTH-1:0] sat;
  logic [OUT_WIDTH-1:0]        proc_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_arr[gi] = src_data[gi*ADC_WIDTH +: ADC_WIDTH];
    end
  endgenerate

  assign sample = src_arr[sel_reg];
  assign diff   = $signed({sample[ADC_WIDTH-1], sample}) - $signed({offset_reg[ADC_WIDTH-1], offset_reg});

  // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
  always_comb begin
    sat = diff[ADC_WIDTH-1:0];
    if (diff[ADC_WIDTH] != diff[ADC_WIDTH-1])
      sat = diff[ADC_WIDTH] ? {1'b1, {(ADC_WIDTH-1){1'b0}}} : {1'b0, {(ADC_WIDTH-1){1'b1}}};
  end

  assign proc_data = OUT_WIDTH'(sat);

  logic handshake, is_last, final_pkt, stop_now, accept, load, drop;

  assign handshake = tvalid_reg & m_tready;
  assign is_last   = (beat_cnt_reg == pkt_len_reg - PKT_LEN_W'(1));
  assign final_pkt = (num_pkts_reg != '0) && (pkt_cnt_reg == num_pkts_reg - PKT_LEN_W'(1));
  assign stop_now  = !cfg_enable && (beat_cnt_reg == '0);
  assign accept    = (state_reg == STREAM) && !stop_now && src_valid[sel_reg];
  // A full register only takes a new sample when its beat leaves in the same cycle.
  assign load      = accept && (!tvalid_reg || m_tready);
  assign drop      = accept && tvalid_reg && !m_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      offset_reg   <= '0;
      pkt_len_reg  <= '0;
      num_pkts_reg <= '0;
      beat_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
      tdata_reg    <= '0;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      drop_reg <= drop;
      if (load) begin
        tdata_reg  <= proc_data;
        tvalid_reg <= 1'b1;
        tlast_reg  <= is_last;
        if (is_last) begin
          beat_cnt_reg <= '0;
          pkt_cnt_reg  <= pkt_cnt_reg + PKT_LEN_W'(1);
        end else begin
          beat_cnt_reg <= beat_cnt_reg + PKT_LEN_W'(1);
        end
      end else if (handshake) begin
        tvalid_reg <= 1'b0;
        tlast_reg  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (start && cfg_enable) begin
            sel_reg      <= cfg_sel_source;
            offset_reg   <= cfg_offset;
            pkt_len_reg  <= (cfg_pkt_len == '0) ? PKT_LEN_W'(1) : cfg_pkt_len;
            num_pkts_reg <= cfg_num_pkts;
            beat_cnt_reg <= '0;
            pkt_cnt_reg  <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= STREAM;
          end
        end
        STREAM: begin
          if (stop_now || (load && is_last && final_pkt))
            state_reg <= DRAIN;
        end
        DRAIN: begin
          if (!tvalid_reg || m_tready) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef PREPROC_DROP_CNT_EN
  logic [31:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt_reg <= '0;
    else if (state_reg == IDLE && start && cfg_enable)
      drop_cnt_reg <= '0;
    else if (drop && drop_cnt_reg != '1)
      drop_cnt_reg <= drop_cnt_reg + 32'd1;
  end

  assign drop_count = drop_cnt_reg;
`endif

  assign m_tdata    = tdata_reg;
  assign m_tvalid   = tvalid_reg;
  assign m_tlast    = tlast_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign drop_pulse = drop_reg;
endmodule

// File: tb/tb_preproc_stream_ctrl.sv
// Randomized scoreboard bench for preproc_stream_ctrl: a cycle-stepped reference model pushes expected beats,
// an independent monitor pops and compares them on every handshake.
`timescale 1ns/1ps
module tb_preproc_stream_ctrl;
  localparam int ADC_WIDTH = 14;
  localparam int NUM_SRC   = 4;
  localparam int SRC_SEL_W = 2;
  localparam int OUT_WIDTH = 16;
  localparam int PKT_LEN_W = 16;
  localparam int SMAX = 2**(ADC_WIDTH-1) - 1;
  localparam int SMIN = -(2**(ADC_WIDTH-1));

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         cfg_enable = 1'b0;
  logic [SRC_SEL_W-1:0]         cfg_sel_source = '0;
  logic [ADC_WIDTH-1:0]         cfg_offset = '0;
  logic [PKT_LEN_W-1:0]         cfg_pkt_len = '0;
  logic [PKT_LEN_W-1:0]         cfg_num_pkts = '0;
  logic                         start = 1'b0;
  logic [NUM_SRC*ADC_WIDTH-1:0] src_data = '0;
  logic [NUM_SRC-1:0]           src_valid = '0;
  logic [OUT_WIDTH-1:0]         m_tdata;
  logic                         m_tvalid;
  logic                         m_tready = 1'b0;
  logic                         m_tlast;
  logic                         busy;
  logic                         done;
  logic                         drop_pulse;
`ifdef PREPROC_DROP_CNT_EN
  logic [31:0]                  drop_count;
`endif

  preproc_stream_ctrl #(
    .ADC_WIDTH(ADC_WIDTH), .NUM_SRC(NUM_SRC), .SRC_SEL_W(SRC_SEL_W),
    .OUT_WIDTH(OUT_WIDTH), .PKT_LEN_W(PKT_LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_sel_source(cfg_sel_source),
    .cfg_offset(cfg_offset), .cfg_pkt_len(cfg_pkt_len), .cfg_num_pkts(cfg_num_pkts),
    .start(start), .src_data(src_data), .src_valid(src_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done), .drop_pulse(drop_pulse)
`ifdef PREPROC_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OUT_WIDTH:0] exp_q[$];   // {tlast, tdata}
  int beats_seen = 0, drop_seen = 0, done_seen = 0;

  // Reference model: 0 idle, 1 streaming, 2 draining, 3 done
  int ref_st = 0, ref_beat = 0, ref_pkt = 0, ref_len = 1, ref_num = 0, ref_sel = 0;
  logic [ADC_WIDTH-1:0] ref_off = '0;
  bit ref_pend = 0;
  int pushed = 0, exp_drops = 0;

  // Stimulus knobs
  bit drv_start = 0, drv_en = 0, noise = 0, arm_hold = 0;
  int tready_pct = 100, hold_cnt = 0, gen_mode = 1, ramp = 0, phase = 0;
  logic [ADC_WIDTH-1:0] gen_const = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_WIDTH-1:0] sat_ref(input logic [ADC_WIDTH-1:0] s, input logic [ADC_WIDTH-1:0] o);
    int d;
    d = int'($signed(s)) - int'($signed(o));
    if (d > SMAX) d = SMAX;
    if (d < SMIN) d = SMIN;
    return OUT_WIDTH'(d);
  endfunction

  // Monitor: pops one expected beat per observed handshake, counts pulses.
  initial begin
    logic [OUT_WIDTH:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (drop_pulse) drop_seen++;
        if (done) done_seen++;
        if (m_tvalid && m_tready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_tdata, e[OUT_WIDTH-1:0]);
            chk("beat_last", m_tlast, e[OUT_WIDTH]);
            $display("beat data=%0d last=%0b", $signed(m_tdata), m_tlast);
          end
        end
      end
    end
  end

  task automatic step();
    logic [ADC_WIDTH-1:0] sd [NUM_SRC];
    logic [ADC_WIDTH-1:0] smp;
    bit strobe, hs, ld, last;
    int tgt;
    @(negedge clk);
    if (!rst) begin
      chk("busy", busy, (ref_st == 1 || ref_st == 2));
      chk("tvalid", m_tvalid, ref_pend);
    end
    start = drv_start;
    drv_start = 0;
    cfg_enable = drv_en;
    if (noise && ref_st != 0) begin
      if ($urandom_range(0, 9) == 0) start = 1'b1;
      cfg_sel_source = SRC_SEL_W'($urandom());
      cfg_offset     = ADC_WIDTH'($urandom());
      cfg_pkt_len    = PKT_LEN_W'($urandom_range(0, 9));
      cfg_num_pkts   = PKT_LEN_W'($urandom_range(0, 3));
    end
    strobe = (phase == 0);
    phase = (phase == 2) ? 0 : phase + 1;
    tgt = (ref_st == 0) ? int'(cfg_sel_source) : ref_sel;
    for (int i = 0; i < NUM_SRC; i++) begin
      sd[i] = ADC_WIDTH'($urandom());
      src_valid[i] = (i == tgt) ? strobe : ($urandom_range(0, 3) == 0);
    end
    if (strobe) begin
      sd[tgt] = (gen_mode == 0) ? ADC_WIDTH'(ramp) : (gen_mode == 2) ? gen_const : sd[tgt];
      if (ref_st == 1) ramp++;
    end
    for (int i = 0; i < NUM_SRC; i++) src_data[i*ADC_WIDTH +: ADC_WIDTH] = sd[i];
    if (arm_hold && ref_pend) begin
      hold_cnt = 7;
      arm_hold = 0;
    end
    if (hold_cnt > 0) begin
      m_tready = 1'b0;
      hold_cnt--;
    end else begin
      m_tready = ($urandom_range(1, 100) <= tready_pct);
    end

    if (rst) return;
    hs = ref_pend && m_tready;
    ld = 0;
    case (ref_st)
      0: if (start && cfg_enable) begin
        ref_sel  = int'(cfg_sel_source);
        ref_off  = cfg_offset;
        ref_len  = (cfg_pkt_len == 0) ? 1 : int'(cfg_pkt_len);
        ref_num  = int'(cfg_num_pkts);
        ref_beat = 0;
        ref_pkt  = 0;
        ref_st   = 1;
      end
      1: if (!cfg_enable && ref_beat == 0) begin
        ref_st = 2;
      end else if (src_valid[ref_sel]) begin
        if (ref_pend && !m_tready) begin
          exp_drops++;
        end else begin
          smp = sd[ref_sel];
          last = (ref_beat == ref_len - 1);
          exp_q.push_back({last, sat_ref(smp, ref_off)});
          pushed++;
          ld = 1;
          if (last) begin
            if (ref_num != 0 && ref_pkt == ref_num - 1) ref_st = 2;
            ref_beat = 0;
            ref_pkt = (ref_pkt + 1) % 65536;
          end else begin
            ref_beat++;
          end
        end
      end
      2: if (!ref_pend || m_tready) ref_st = 3;
      default: ref_st = 0;
    endcase
    ref_pend = ld ? 1'b1 : (hs ? 1'b0 : ref_pend);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ref_st = 0;
    ref_pend = 0;
    exp_q.delete();
    repeat (n) step();
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", drop_pulse, 0);
    rst = 1'b0;
  endtask

  task automatic start_run(input int sel, input int off, input int len, input int num);
    cfg_sel_source = SRC_SEL_W'(sel);
    cfg_offset     = ADC_WIDTH'(off);
    cfg_pkt_len    = PKT_LEN_W'(len);
    cfg_num_pkts   = PKT_LEN_W'(num);
    drv_en = 1;
    drv_start = 1;
    ramp = 0;
    pushed = 0;
    exp_drops = 0;
    drop_seen = 0;
    done_seen = 0;
    beats_seen = 0;
    step();
  endtask

  task automatic run_until_pushed(input int k);
    int n = 0;
    while (pushed < k && ref_st != 0 && n < 2000) begin
      step();
      n++;
    end
    chk("push_timeout", (pushed >= k), 1);
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while (ref_st != 0 && n < 4000) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, (ref_st == 0), 1);
    repeat (3) step();
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_drops"}, drop_seen, exp_drops);
    chk({tag, "_done_pulses"}, done_seen, 1);
    chk({tag, "_busy_after"}, busy, 0);
`ifdef PREPROC_DROP_CNT_EN
    chk({tag, "_drop_count"}, drop_count, exp_drops);
`endif
    $display("run %s: beats=%0d drops=%0d", tag, beats_seen, drop_seen);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);

    // Ramp through source 1 with offset 100, two packets of 8
    noise = 0; gen_mode = 0; tready_pct = 100;
    start_run(1, 100, 8, 2);
    finish_run("ramp");
    chk("ramp_beats", beats_seen, 16);
    chk("ramp_no_drops", drop_seen, 0);

    // Saturation both directions
    gen_mode = 2; gen_const = ADC_WIDTH'(8000);
    start_run(0, -8000, 2, 1);
    finish_run("sat_pos");
    gen_const = ADC_WIDTH'(-8000);
    start_run(3, 8000, 3, 1);
    finish_run("sat_neg");

    // Held ready after the first beat
    gen_mode = 1; arm_hold = 1;
    start_run(1, 0, 4, 3);
    finish_run("backpressure");
    chk("bp_drops", drop_seen, 2);
    chk("bp_beats", beats_seen, 12);

    // Continuous mode, enable dropped mid-packet 2
    start_run(0, 0, 5, 0);
    run_until_pushed(7);
    drv_en = 0;
    finish_run("cont_stop");
    chk("cont_beats", beats_seen, 10);

    // Reset on the third beat of the first packet, then a clean run
    start_run(2, 50, 6, 3);
    run_until_pushed(3);
    do_reset(0);
    start_run(2, 50, 6, 1);
    finish_run("after_rst");
    chk("after_rst_beats", beats_seen, 6);

    // Stray starts, cfg churn and unselected strobes during a run
    noise = 1;
    start_run(3, -20, 4, 2);
    finish_run("ignored_ctrl");
    chk("ignored_beats", beats_seen, 8);

    // Random runs
    for (int r = 0; r < 8; r++) begin
      int num;
      tready_pct = $urandom_range(30, 100);
      num = $urandom_range(0, 3);
      start_run($urandom_range(0, 3), int'($urandom_range(0, 16383)), $urandom_range(0, 6), num);
      if (num == 0) begin
        run_until_pushed($urandom_range(1, 12));
        drv_en = 0;
      end
      finish_run($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/preproc_stream_ctrl.md
Name: preproc_stream_ctrl

Overview:
Sequencer for the preprocessing datapath.
- Selects one of NUM_SRC sample sources, e.g. ADC or a test-tone generator.
- Subtracts a programmable DC offset with saturation.
- Frames the result into fixed-length AXI-Stream packets.
- Runs for a programmed packet count, or continuously, under start/enable control from the AXI-Lite register bank.
- Sits between the ADC/tone sources and the downstream filter stage.

Parameters:
- ADC_WIDTH, 14, sample width (signed, two's complement).
- NUM_SRC, 4, number of selectable sources.
- SRC_SEL_W, 2, width of source select (clog2 NUM_SRC).
- OUT_WIDTH, 16, output sample width (sign-extended); must be ≥ ADC_WIDTH.
- PKT_LEN_W, 16, width of the packet-length and packet-count fields.

Ports:
- clk, in, 1, single clock, 260 MHz ADC domain.
- rst, in, 1, synchronous, active-high reset.
- cfg_enable, in, 1, master enable; deassertion requests a stop at the next packet boundary.
- cfg_sel_source, in, SRC_SEL_W, source index; latched on start.
- cfg_offset, in, ADC_WIDTH, signed offset; latched on start.
- cfg_pkt_len, in, PKT_LEN_W, samples per packet; latched on start; 0 is treated as 1.
- cfg_num_pkts, in, PKT_LEN_W, packets per run; latched on start; 0 means continuous.
- start, in, 1, single-cycle run request.
- src_data, in, NUM_SRC*ADC_WIDTH, packed source samples; source k occupies bits [k*ADC_WIDTH +: ADC_WIDTH].
- src_valid, in, NUM_SRC, per-source sample strobe (typically 1 every CLOCKS_PER_SAMPLE=3 clocks).
- m_tdata, out, OUT_WIDTH, processed sample.
- m_tvalid, out, 1, AXI-Stream valid.
- m_tready, in, 1, AXI-Stream ready.
- m_tlast, out, 1, last beat of a packet.
- busy, out, 1, high in STREAM and DRAIN.
- done, out, 1, one-cycle pulse when a run completes.
- drop_pulse, out, 1, one-cycle pulse per discarded sample.

Behaviour:
Reset:
- State IDLE.
- m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, done=0, drop_pulse=0.
- All counters and latched config cleared.
- Reset asserted mid-run aborts immediately; no tlast is emitted.

States:
- IDLE:
  - start & cfg_enable → STREAM; cfg_* latched, beat_cnt=0, pkt_cnt=0.
  - start while cfg_enable=0 is ignored.
- STREAM:
  - Accepts src_valid[sel] samples.
  - End of the final packet (pkt_cnt == num_pkts-1, num_pkts≠0) → DRAIN.
  - cfg_enable low at a packet boundary → DRAIN.
  - cfg_enable falling mid-packet: the current packet completes at full length, then → DRAIN.
- DRAIN:
  - No new samples accepted.
  - Waits for handshake of the pending beat (m_tvalid & m_tready), then → DONE.
  - Goes to DONE immediately if no beat is pending.
- DONE: done=1 for exactly one cycle → IDLE.
- start in any state other than IDLE is ignored.

Datapath:
- diff = sext(sample, ADC_WIDTH+1) − sext(offset, ADC_WIDTH+1).
- Saturate diff to [−2^(ADC_WIDTH−1), 2^(ADC_WIDTH−1)−1]; sign-extend to OUT_WIDTH.
- Latency: sample with src_valid at cycle N → m_tvalid=1 with data at cycle N+1.

Output register (one entry):
- Loads on an accepted sample when empty, or when the pending beat handshakes in the same cycle.
- Simultaneous load and handshake is a seamless back-to-back beat.
- Sample arrives while the register is full and m_tready=0: sample discarded, drop_pulse=1 next cycle, beat_cnt unchanged (packets are always full length).
- m_tvalid, once high, stays high with stable m_tdata and m_tlast until handshake.

Framing:
- m_tlast=1 when the loaded beat has beat_cnt == pkt_len−1.
- beat_cnt wraps to 0 and pkt_cnt increments on loading a tlast beat.
- pkt_cnt wraps at 2^PKT_LEN_W in continuous mode.

Other inputs:
- src_valid of unselected sources is ignored.
- cfg_* changes during a run have no effect, except cfg_enable.

Optional Feature:
PREPROC_DROP_CNT_EN
- Enabled:
  - Adds output drop_count (32 bits), counting discarded samples and saturating at 0xFFFF_FFFF.
  - Cleared on rst and on the start that launches a run.
  - Readable through the register bank.
- Disabled: port absent; only drop_pulse exists.

Test Plan:
1. Setup: sel=1, offset=100, pkt_len=8, num_pkts=2, m_tready=1; source 1 ramps 0..15, one sample every 3 clocks.
   Expected: 16 beats with data −100..−85; tlast on beats 8 and 16; done pulses once; busy low after; zero drops.
2. Saturation: offset=−8000, sample=+8000 → data=+8191 (0x1FFF). Offset=+8000, sample=−8000 → data=−8192 (sign-extended 0xE000).
3. Backpressure: m_tready=0 for 7 clocks, pkt_len=4.
   Expected: first beat held stable; the next 2 samples dropped with 2 drop_pulses; packets remain 4 beats; tlast on every 4th delivered beat.
4. Continuous stop: num_pkts=0, pkt_len=5; deassert cfg_enable after sample 7.
   Expected: packet 2 completes (10 beats total, tlast on beats 5 and 10); then done; busy falls.
5. Mid-run reset: assert rst during packet 1, beat 3.
   Expected: next cycle m_tvalid=0, m_tlast=0, busy=0, state IDLE; a new start resumes with beat_cnt=0.
6. Ignored controls:
   - start while busy → no effect.
   - cfg_sel_source change mid-run → output still from the latched source.
   - Pulses on an unselected src_valid → no beats.
